// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: special instruction
// encodings and the fetch FSM state encoding.
package if_stage_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), used as the bubble word.
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  // ecall encoding, treated by this core as "stop fetching".
  localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

  // Fetch FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // True when a fetched word must stop the fetch engine.
  function automatic logic is_halt(input logic [31:0] instr);
    return instr == HALT_INSTR;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: 2**PC_SIZE 32-bit words, one synchronous write port
// (used for program loading) and one combinational read port (used by fetch).
module instr_mem #(
  parameter int PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               i_we,
  input  logic [PC_SIZE-1:0] i_waddr,
  input  logic [31:0]        i_wdata,
  input  logic [PC_SIZE-1:0] i_raddr,
  output logic [31:0]        o_rdata
);

  localparam int DEPTH = 1 << PC_SIZE;

  logic [31:0] r_mem [DEPTH];

  // Synchronous program write.
  // NOTE: the array deliberately has no reset branch; a loaded program must
  // survive a core reset, and a reset loop over a RAM would block RAM inference.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read so the fetched word is available in the same cycle as PC.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC and the LOAD/RUN/HALT fetch FSM,
// reads the instruction memory and registers PC/instruction/valid for decode.
// Control priority: reset > prog_mode > branch_taken > flush > stall > fetch.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_mode,
  input  logic               prog_we,
  input  logic [PC_SIZE-1:0] prog_addr,
  input  logic [31:0]        prog_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_SIZE-1:0] branch_target,
  output logic [PC_SIZE-1:0] PC_out,
  output logic [31:0]        instruction,
  output logic               valid,
  output logic               halted
);

  state_t             r_state;
  logic [PC_SIZE-1:0] r_pc;
  logic [PC_SIZE-1:0] r_pc_out;
  logic [31:0]        r_instr;
  logic               r_valid;

  state_t             w_state_nxt;
  logic [PC_SIZE-1:0] w_pc_nxt;
  logic [PC_SIZE-1:0] w_pc_out_nxt;
  logic [31:0]        w_instr_nxt;
  logic               w_valid_nxt;

  logic               w_mem_we;
  logic [31:0]        w_rdata;

  // Writes are accepted only once the FSM is actually in LOAD and prog_mode
  // is still held; reset takes precedence over any write.
  assign w_mem_we = prog_mode && prog_we && (r_state == ST_LOAD) && !reset;

  instr_mem #(
    .PC_SIZE (PC_SIZE)
  ) u_instr_mem (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  // Next-state and next-output selection for the fetch FSM.
  // NOTE: every signal driven here gets a default first, so paths that do not
  // mention a signal (e.g. stall) hold it rather than inferring a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_out_nxt = r_pc_out;
    w_instr_nxt  = r_instr;
    w_valid_nxt  = r_valid;

    if (prog_mode) begin
      w_state_nxt  = ST_LOAD;
      w_pc_nxt     = '0;
      w_pc_out_nxt = '0;
      w_instr_nxt  = NOP_INSTR;
      w_valid_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (branch_taken) begin
            // Redirect: the target is fetched next cycle, a bubble goes out now.
            w_pc_nxt     = branch_target;
            w_pc_out_nxt = '0;
            w_instr_nxt  = NOP_INSTR;
            w_valid_nxt  = 1'b0;
          end else if (flush) begin
            w_pc_out_nxt = '0;
            w_instr_nxt  = NOP_INSTR;
            w_valid_nxt  = 1'b0;
          end else if (!stall) begin
            // Normal fetch; PC wraps naturally at 2**PC_SIZE.
            w_pc_nxt     = r_pc + PC_SIZE'(1);
            w_pc_out_nxt = r_pc;
            w_instr_nxt  = w_rdata;
            w_valid_nxt  = 1'b1;
            if (is_halt(w_rdata)) begin
              w_state_nxt = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          // Frozen: PC held, control inputs ignored, bubble presented.
          w_pc_out_nxt = '0;
          w_instr_nxt  = NOP_INSTR;
          w_valid_nxt  = 1'b0;
        end
        default: begin
          // Leaving LOAD (or recovering an illegal encoding): restart at 0.
          w_state_nxt  = ST_RUN;
          w_pc_nxt     = '0;
          w_pc_out_nxt = '0;
          w_instr_nxt  = NOP_INSTR;
          w_valid_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset into RUN at PC 0.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_pc     <= '0;
      r_pc_out <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign PC_out      = r_pc_out;
  assign instruction = r_instr;
  assign valid       = r_valid;
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: each cycle pushes the expected outputs
// to a scoreboard queue and compares them after the clock edge.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int PC_SIZE = 10;

  logic               clock = 1'b0;
  logic               reset;
  logic               prog_mode;
  logic               prog_we;
  logic [PC_SIZE-1:0] prog_addr;
  logic [31:0]        prog_data;
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [PC_SIZE-1:0] branch_target;
  logic [PC_SIZE-1:0] PC_out;
  logic [31:0]        instruction;
  logic               valid;
  logic               halted;

  always #5 clock = ~clock;

  if_stage #(
    .PC_SIZE (PC_SIZE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .prog_mode     (prog_mode),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .PC_out        (PC_out),
    .instruction   (instruction),
    .valid         (valid),
    .halted        (halted)
  );

  typedef struct {
    string              tag;
    logic [PC_SIZE-1:0] pc;
    logic [31:0]        instr;
    logic               valid;
    logic               halted;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program word used for the bulk-loaded region.
  function automatic logic [31:0] word_at(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // One clock: push expectation, clock, pop and compare, return strobes to idle.
  task automatic tick(input string tag, input logic [PC_SIZE-1:0] pc,
                      input logic [31:0] ins, input logic v, input logic h);
    exp_t e;
    exp_t o;
    e.tag = tag; e.pc = pc; e.instr = ins; e.valid = v; e.halted = h;
    sb.push_back(e);
    @(posedge clock);
    #1;
    o = sb.pop_front();
    check({o.tag, ".pc"},     32'(PC_out), 32'(o.pc));
    check({o.tag, ".instr"},  instruction, o.instr);
    check({o.tag, ".valid"},  32'(valid),  32'(o.valid));
    check({o.tag, ".halted"}, 32'(halted), 32'(o.halted));
    reset        = 1'b0;
    prog_we      = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic load(input logic [PC_SIZE-1:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick("load", '0, NOP_INSTR, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick("reset", '0, NOP_INSTR, 1'b0, 1'b0);

    // Two-word program ending in HALT.
    prog_mode = 1'b1;
    tick("enter_load", '0, NOP_INSTR, 1'b0, 1'b0);
    load(10'd0, 32'h00A0_0093);
    load(10'd1, HALT_INSTR);
    prog_mode = 1'b0;
    tick("release", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("fetch0", 10'd0, 32'h00A0_0093, 1'b1, 1'b0);
    tick("fetch_halt", 10'd1, HALT_INSTR, 1'b1, 1'b1);
    tick("halt_bubble", '0, NOP_INSTR, 1'b0, 1'b1);
    stall = 1'b1; flush = 1'b1; branch_taken = 1'b1; branch_target = 10'h100;
    tick("halt_ignore", '0, NOP_INSTR, 1'b0, 1'b1);
    reset = 1'b1;
    tick("reset_halt", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("refetch0", 10'd0, 32'h00A0_0093, 1'b1, 1'b0);

    // Larger program for stall, branch, wrap, flush and write-protection.
    prog_mode = 1'b1;
    tick("enter_load2", '0, NOP_INSTR, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) load(PC_SIZE'(i), word_at(i));
    load(10'h200, 32'h2000_0200);
    load(10'h3FF, 32'hCAFE_F00D);
    prog_mode = 1'b0;
    tick("release2", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("f0", 10'd0, word_at(0), 1'b1, 1'b0);
    tick("f1", 10'd1, word_at(1), 1'b1, 1'b0);
    prog_we = 1'b1; prog_addr = 10'd3; prog_data = 32'hBADB_AD00;
    tick("f2_we_run", 10'd2, word_at(2), 1'b1, 1'b0);
    tick("f3_unchanged", 10'd3, word_at(3), 1'b1, 1'b0);
    tick("f4", 10'd4, word_at(4), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      tick("stall", 10'd4, word_at(4), 1'b1, 1'b0);
    end
    tick("after_stall", 10'd5, word_at(5), 1'b1, 1'b0);
    tick("f6", 10'd6, word_at(6), 1'b1, 1'b0);
    branch_taken = 1'b1; flush = 1'b1; branch_target = 10'h200;
    tick("branch_bubble", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("branch_target", 10'h200, 32'h2000_0200, 1'b1, 1'b0);
    branch_taken = 1'b1; branch_target = 10'h3FF;
    tick("branch_max", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("pc_max", 10'h3FF, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick("pc_wrap", 10'd0, word_at(0), 1'b1, 1'b0);
    flush = 1'b1;
    tick("flush", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("after_flush", 10'd1, word_at(1), 1'b1, 1'b0);
    stall = 1'b1; reset = 1'b1;
    tick("reset_stall", '0, NOP_INSTR, 1'b0, 1'b0);
    tick("refetch_s", 10'd0, word_at(0), 1'b1, 1'b0);
    prog_mode = 1'b1;
    tick("enter_load3", '0, NOP_INSTR, 1'b0, 1'b0);
    reset = 1'b1;
    tick("reset_load", '0, NOP_INSTR, 1'b0, 1'b0);
    prog_mode = 1'b0;
    tick("refetch_l0", 10'd0, word_at(0), 1'b1, 1'b0);
    tick("refetch_l1", 10'd1, word_at(1), 1'b1, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_SIZE, default 10, PC width in bits; instruction memory depth SHALL be 2**PC_SIZE 32-bit words.
REQ-002 clock  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 prog_mode  input  1  high = LOAD mode; fetch suspended, instruction memory writable.
REQ-005 prog_we  input  1  instruction memory write strobe; honoured only while prog_mode=1.
REQ-006 prog_addr  input  PC_SIZE  word address for program write.
REQ-007 prog_data  input  32  instruction word to write.
REQ-008 stall  input  1  hold PC and all outputs for this cycle.
REQ-009 flush  input  1  squash the fetch of this cycle into a bubble.
REQ-010 branch_taken  input  1  redirect fetch to branch_target.
REQ-011 branch_target  input  PC_SIZE  word address of redirect target.
REQ-012 PC_out  output  PC_SIZE  registered word address of the instruction presented to decode.
REQ-013 instruction  output  32  registered instruction word for decode.
REQ-014 valid  output  1  registered; high when instruction is a real fetched word, low for bubbles.
REQ-015 halted  output  1  high while the FSM is in HALT.

Function
REQ-016 The block SHALL hold an internal PC register; PC SHALL be a word address, incremented by 1 per fetch.
REQ-017 The FSM SHALL have states LOAD, RUN and HALT.
REQ-018 The bubble SHALL be the NOP 0x00000013 with valid=0 and PC_out=0.
REQ-019 In RUN, with no control input asserted, each cycle SHALL register PC_out<=PC, instruction<=imem[PC], valid<=1, PC<=PC+1 (latency 1 cycle from PC to outputs).
REQ-020 PC increment SHALL wrap modulo 2**PC_SIZE (1023+1 -> 0 at PC_SIZE=10).
REQ-021 Priority SHALL be reset > prog_mode > branch_taken > flush > stall > normal fetch.
REQ-022 branch_taken in RUN SHALL set PC<=branch_target and register a bubble; the target's instruction SHALL appear on the following cycle.
REQ-023 flush in RUN (no branch_taken) SHALL register a bubble and hold PC unchanged.
REQ-024 stall in RUN (no branch/flush) SHALL hold PC, PC_out, instruction and valid unchanged.
REQ-025 Fetching 0x00000073 in RUN SHALL present that word normally (valid=1), then enter HALT on the same edge.
REQ-026 In HALT, outputs SHALL be the bubble, PC SHALL be frozen and halted=1; stall/flush/branch_taken SHALL be ignored.
REQ-027 prog_mode=1 in any state SHALL enter LOAD; in LOAD outputs SHALL be the bubble and PC SHALL be 0.
REQ-028 In LOAD, prog_we=1 SHALL write prog_data to imem[prog_addr] at the clock edge; prog_we outside LOAD SHALL be ignored.
REQ-029 prog_mode falling SHALL enter RUN with PC=0; the first fetch (address 0) SHALL appear on outputs one cycle later.
REQ-030 Instruction memory read SHALL be combinational on PC; memory write SHALL be synchronous.

Reset
REQ-031 On reset the FSM SHALL enter RUN, with PC=0, PC_out=0, instruction=0x00000013, valid=0 and halted=0.
REQ-032 Reset SHALL NOT clear instruction memory contents.
REQ-033 Reset asserted mid-stall, mid-HALT or mid-LOAD SHALL produce the REQ-031 state on the next edge.

Structure
REQ-034 A shared package SHALL hold the NOP_INSTR and HALT_INSTR constants and the FSM state encoding (2 bits).
REQ-035 Instruction memory SHALL be a sub-module instr_mem (parameter PC_SIZE: one sync write port, one async read port); the PC and FSM SHALL live in if_stage.

Verification
REQ-036 Load 0x00A00093 at 0 and 0x00000073 at 1, release prog_mode -> PC_out 0/instr 0x00A00093/valid 1, then PC_out 1/instr 0x00000073, then halted=1 with bubble outputs held.
REQ-037 In RUN at PC=5, assert stall for 3 cycles -> outputs frozen at PC_out 4; after release PC_out 5 appears next cycle.
REQ-038 At PC=7, branch_taken=1 with target 0x200 and flush=1 together -> one bubble, then PC_out 0x200 with instr imem[0x200].
REQ-039 Preload imem[1023]=X and imem[0]=Y, branch to 1023 -> PC_out 1023/X, then PC_out 0/Y (wrap).
REQ-040 Assert reset during HALT and during LOAD -> next cycle RUN, PC=0, bubble outputs, memory contents intact (address 0 re-fetched correctly).
REQ-041 Pulse prog_we=1 with prog_mode=0 at address 3 -> imem[3] unchanged when fetched.
